// File: rtl/arm_pkg.sv
// arm_pkg: shared ARM core ALU command encodings, status bit positions and width defaults
package arm_pkg;
  localparam int DEF_DW = 32;
  localparam int DEF_RW = 4;
  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_CMP = EXE_SUB;
  localparam logic [3:0] EXE_TST = EXE_AND;
  localparam int Z_BIT = 3;
  localparam int C_BIT = 2;
  localparam int N_BIT = 1;
  localparam int V_BIT = 0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones; ports clk, rst (async active-low), inc_i, cnt_o
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/id_exe_reg.sv
// id_exe_reg: decode->execute pipeline slot with flush/freeze and stall/bubble counters
//   ports: clk, rst (async active-low), freeze, flush, decode *_in -> registered *_out,
//          valid_out (slot holds a real instruction), stall_cnt, bubble_cnt
module id_exe_reg
  import arm_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int RW = DEF_RW,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          flush,
  input  logic          WB_EN_in,
  input  logic          MEM_R_EN_in,
  input  logic          MEM_W_EN_in,
  input  logic          B_in,
  input  logic          S_in,
  input  logic [3:0]    EXE_CMD_in,
  input  logic [DW-1:0] PC_in,
  input  logic [DW-1:0] Val_RN_in,
  input  logic [DW-1:0] Val_RM_in,
  input  logic          imm_in,
  input  logic [11:0]   shift_operand_in,
  input  logic [23:0]   signed_imm_24_in,
  input  logic [RW-1:0] Dest_in,
  input  logic [RW-1:0] src1_in,
  input  logic [RW-1:0] src2_in,
  input  logic [3:0]    status_in,
  output logic          WB_EN_out,
  output logic          MEM_R_EN_out,
  output logic          MEM_W_EN_out,
  output logic          B_out,
  output logic          S_out,
  output logic [3:0]    EXE_CMD_out,
  output logic [DW-1:0] PC_out,
  output logic [DW-1:0] Val_RN_out,
  output logic [DW-1:0] Val_RM_out,
  output logic          imm_out,
  output logic [11:0]   shift_operand_out,
  output logic [23:0]   signed_imm_24_out,
  output logic [RW-1:0] Dest_out,
  output logic [RW-1:0] src1_out,
  output logic [RW-1:0] src2_out,
  output logic [3:0]    status_out,
  output logic          valid_out,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] bubble_cnt
);
  localparam int PW = 5 + 4 + 3 * DW + 1 + 12 + 24 + 3 * RW + 4 + 1;
  logic [PW-1:0] slot_q, slot_d;
  logic valid_in;
  // compare/test ops only raise S, so S alone still marks a live instruction
  assign valid_in = WB_EN_in | MEM_R_EN_in | MEM_W_EN_in | B_in | S_in;
  // whole slot moves as one vector so control and data can never split
  assign slot_d = flush ? '0 : freeze ? slot_q :
                  {WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, EXE_CMD_in,
                   PC_in, Val_RN_in, Val_RM_in, imm_in, shift_operand_in,
                   signed_imm_24_in, Dest_in, src1_in, src2_in, status_in, valid_in};
  always_ff @(posedge clk or negedge rst)
    if (!rst) slot_q <= '0;
    else slot_q <= slot_d;
  assign {WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, EXE_CMD_out,
          PC_out, Val_RN_out, Val_RM_out, imm_out, shift_operand_out,
          signed_imm_24_out, Dest_out, src1_out, src2_out, status_out, valid_out} = slot_q;
  sat_counter #(.W(CW)) u_stall (
    .clk  (clk),
    .rst  (rst),
    .inc_i(freeze & ~flush),
    .cnt_o(stall_cnt)
  );
  sat_counter #(.W(CW)) u_bubble (
    .clk  (clk),
    .rst  (rst),
    .inc_i(flush),
    .cnt_o(bubble_cnt)
  );
endmodule

// File: tb/tb_id_exe_reg.sv
// tb_id_exe_reg: randomized and directed self-checking bench for id_exe_reg against a slot-level model
module tb_id_exe_reg;
  localparam int DW = 32;
  localparam int RW = 4;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  typedef struct packed {
    logic wb, mr, mw, b, s;
    logic [3:0] cmd;
    logic [DW-1:0] pc, rn, rm;
    logic imm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [RW-1:0] dst, s1, s2;
    logic [3:0] st;
    logic v;
  } slot_t;
  logic clk = 0, rst = 1, freeze = 0, flush = 0;
  slot_t in_s, got, exp_s;
  int exp_stall, exp_bubble, pass_cnt, total;
  logic wb_o, mr_o, mw_o, b_o, s_o, imm_o, v_o;
  logic [3:0] cmd_o, st_o;
  logic [DW-1:0] pc_o, rn_o, rm_o;
  logic [11:0] sh_o;
  logic [23:0] si_o;
  logic [RW-1:0] dst_o, s1_o, s2_o;
  logic [CW-1:0] stall_cnt, bubble_cnt;
  always #5 clk = ~clk;
  id_exe_reg #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .WB_EN_in(in_s.wb), .MEM_R_EN_in(in_s.mr), .MEM_W_EN_in(in_s.mw), .B_in(in_s.b), .S_in(in_s.s),
    .EXE_CMD_in(in_s.cmd), .PC_in(in_s.pc), .Val_RN_in(in_s.rn), .Val_RM_in(in_s.rm),
    .imm_in(in_s.imm), .shift_operand_in(in_s.sh), .signed_imm_24_in(in_s.si),
    .Dest_in(in_s.dst), .src1_in(in_s.s1), .src2_in(in_s.s2), .status_in(in_s.st),
    .WB_EN_out(wb_o), .MEM_R_EN_out(mr_o), .MEM_W_EN_out(mw_o), .B_out(b_o), .S_out(s_o),
    .EXE_CMD_out(cmd_o), .PC_out(pc_o), .Val_RN_out(rn_o), .Val_RM_out(rm_o),
    .imm_out(imm_o), .shift_operand_out(sh_o), .signed_imm_24_out(si_o),
    .Dest_out(dst_o), .src1_out(s1_o), .src2_out(s2_o), .status_out(st_o),
    .valid_out(v_o), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );
  assign got = {wb_o, mr_o, mw_o, b_o, s_o, cmd_o, pc_o, rn_o, rm_o, imm_o, sh_o, si_o,
                dst_o, s1_o, s2_o, st_o, v_o};
  task automatic rand_in();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    in_s = r[158:0];
    in_s.v = 1'b0;
  endtask
  // model: a flushed slot is empty, a frozen slot keeps its contents, otherwise the
  // slot takes the decoded instruction, live when it writes, touches memory, branches or sets flags
  task automatic clock(input logic fr, input logic fl);
    freeze = fr;
    flush = fl;
    if (fl) begin
      exp_s = '0;
      exp_bubble = (exp_bubble + 1 > SAT) ? SAT : exp_bubble + 1;
    end else if (fr) begin
      exp_stall = (exp_stall + 1 > SAT) ? SAT : exp_stall + 1;
    end else begin
      exp_s = in_s;
      exp_s.v = in_s.wb || in_s.mr || in_s.mw || in_s.b || in_s.s;
    end
    @(posedge clk);
    #1;
    freeze = 0;
    flush = 0;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 0;
    exp_s = '0;
    exp_stall = 0;
    exp_bubble = 0;
    @(negedge clk) rst = 1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      rand_in();
      clock(i == 2, i == 3);
    end
    rand_in();
    freeze = 1;
    #3 rst = 0;
    #1;
    total++;
    if (got !== '0) $display("FAIL reset_slot got=%h exp=0", got); else pass_cnt++;
    total++;
    if (stall_cnt !== 0 || bubble_cnt !== 0)
      $display("FAIL reset_cnt stall=%0d bubble=%0d exp=0/0", stall_cnt, bubble_cnt);
    else pass_cnt++;
    freeze = 0;
    exp_s = '0;
    exp_stall = 0;
    exp_bubble = 0;
    @(negedge clk) rst = 1;
    in_s = '0;
    clock(0, 0);
    total++;
    if (got !== '0 || v_o !== 1'b0) $display("FAIL reset_idle got=%h exp=0", got); else pass_cnt++;
  endtask
  task automatic test_load();
    do_reset();
    in_s = '0;
    in_s.wb = 1;
    in_s.cmd = 4'b0100;
    in_s.rn = 32'h0000_0005;
    in_s.dst = 4'd3;
    clock(0, 0);
    total++;
    if (wb_o !== 1'b1 || cmd_o !== 4'b0100 || rn_o !== 32'h5 || dst_o !== 4'd3 || v_o !== 1'b1)
      $display("FAIL load got wb=%b cmd=%h rn=%h dst=%h v=%b exp 1/4/5/3/1", wb_o, cmd_o, rn_o, dst_o, v_o);
    else pass_cnt++;
    in_s = '0;
    in_s.s = 1;
    in_s.cmd = 4'b0110;
    clock(0, 0);
    total++;
    if (v_o !== 1'b1 || s_o !== 1'b1) $display("FAIL load_s_only v=%b s=%b exp 1/1", v_o, s_o); else pass_cnt++;
    in_s = '0;
    in_s.mr = 1;
    in_s.mw = 1;
    clock(0, 0);
    total++;
    if (mr_o !== 1'b1 || mw_o !== 1'b1) $display("FAIL illegal_mem mr=%b mw=%b exp 1/1", mr_o, mw_o); else pass_cnt++;
    in_s = '0;
    in_s.pc = 32'h44;
    clock(0, 0);
    total++;
    if (v_o !== 1'b0 || pc_o !== 32'h44) $display("FAIL load_no_ctrl v=%b pc=%h exp 0/44", v_o, pc_o); else pass_cnt++;
  endtask
  task automatic test_freeze();
    do_reset();
    rand_in();
    in_s.pc = 32'h10;
    clock(0, 0);
    in_s.pc = 32'h14;
    for (int i = 0; i < 3; i++) clock(1, 0);
    total++;
    if (pc_o !== 32'h10 || got !== exp_s) $display("FAIL freeze_hold pc=%h exp=10", pc_o); else pass_cnt++;
    total++;
    if (stall_cnt !== 3) $display("FAIL freeze_stall_cnt got=%0d exp=3", stall_cnt); else pass_cnt++;
    clock(0, 0);
    total++;
    if (pc_o !== 32'h14) $display("FAIL freeze_release pc=%h exp=14", pc_o); else pass_cnt++;
  endtask
  task automatic test_flush_priority();
    do_reset();
    rand_in();
    in_s.wb = 1;
    clock(0, 0);
    in_s.mw = 1;
    clock(1, 1);
    total++;
    if (mw_o !== 1'b0 || v_o !== 1'b0 || got !== '0)
      $display("FAIL flush_prio mw=%b v=%b got=%h exp all 0", mw_o, v_o, got);
    else pass_cnt++;
    total++;
    if (bubble_cnt !== 1 || stall_cnt !== 0)
      $display("FAIL flush_prio_cnt bubble=%0d stall=%0d exp 1/0", bubble_cnt, stall_cnt);
    else pass_cnt++;
  endtask
  task automatic test_saturation();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      clock(1, 0);
      if (i >= SAT - 1 && stall_cnt !== 4'hF) bad++;
    end
    total++;
    if (bad != 0 || stall_cnt !== 4'hF) $display("FAIL stall_sat got=%h exp=f bad=%0d", stall_cnt, bad); else pass_cnt++;
    for (int i = 0; i < 18; i++) clock(0, 1);
    total++;
    if (bubble_cnt !== 4'hF) $display("FAIL bubble_sat got=%h exp=f", bubble_cnt); else pass_cnt++;
  endtask
  task automatic test_back_to_back();
    do_reset();
    rand_in();
    in_s.wb = 1;
    clock(0, 0);
    clock(0, 1);
    total++;
    if (got !== '0) $display("FAIL b2b_bubble got=%h exp=0", got); else pass_cnt++;
    in_s = '0;
    in_s.b = 1;
    in_s.si = 24'hFFFFFE;
    clock(0, 0);
    total++;
    if (b_o !== 1'b1 || si_o !== 24'hFFFFFE || v_o !== 1'b1)
      $display("FAIL b2b_load b=%b si=%h v=%b exp 1/fffffe/1", b_o, si_o, v_o);
    else pass_cnt++;
  endtask
  task automatic test_random();
    int bad_slot, bad_cnt;
    logic fr, fl;
    do_reset();
    bad_slot = 0;
    bad_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      rand_in();
      fr = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 5) == 0);
      clock(fr, fl);
      if (got !== exp_s) begin
        bad_slot++;
        if (bad_slot < 4) $display("FAIL random_slot cyc=%0d got=%h exp=%h", i, got, exp_s);
      end
      if (stall_cnt !== exp_stall[CW-1:0] || bubble_cnt !== exp_bubble[CW-1:0]) begin
        bad_cnt++;
        if (bad_cnt < 4)
          $display("FAIL random_cnt cyc=%0d stall=%0d/%0d bubble=%0d/%0d", i, stall_cnt, exp_stall, bubble_cnt, exp_bubble);
      end
    end
    total++;
    if (bad_slot == 0) pass_cnt++;
    total++;
    if (bad_cnt == 0) pass_cnt++;
  endtask
  initial begin
    pass_cnt = 0;
    total = 0;
    in_s = '0;
    exp_s = '0;
    exp_stall = 0;
    exp_bubble = 0;
    test_reset();
    test_load();
    test_freeze();
    test_flush_priority();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
